// File: rtl/lcd_hd44780_writer_if.sv
// Host-side write port of the HD44780 byte writer.
// The host drives a byte and register select; the writer answers with ready/busy.
interface lcd_hd44780_writer_if;
    logic       wr_valid;
    logic       wr_rs;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       busy;

    modport master (
        output wr_valid, wr_rs, wr_data,
        input  wr_ready, busy
    );

    modport slave (
        input  wr_valid, wr_rs, wr_data,
        output wr_ready, busy
    );
endinterface

// File: rtl/lcd_hd44780_writer.sv
// HD44780 8-bit write-only byte engine: SETUP/PULSE/HOLD/WAIT strobe timing.
// Optional power-up init sequence enabled by defining LCD_INIT_EN.
module lcd_hd44780_writer #(
    parameter int unsigned SETUP_CYC = 4,
    parameter int unsigned PULSE_CYC = 16,
    parameter int unsigned HOLD_CYC  = 4,
    parameter int unsigned EXEC_CYC  = 2500,
    parameter int unsigned CLEAR_CYC = 82000,
    parameter int unsigned PWRUP_CYC = 750000,
    parameter int unsigned CNT_W     = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    lcd_hd44780_writer_if.slave wr,
    output logic                lcd_rs,
    output logic                lcd_rw,
    output logic                lcd_e,
    output logic [7:0]          lcd_db
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT, S_PWRUP
    } state_e;

    localparam int unsigned EXEC_T  = (EXEC_CYC > HOLD_CYC) ? EXEC_CYC : HOLD_CYC;
    localparam int unsigned CLEAR_T = (CLEAR_CYC > HOLD_CYC) ? CLEAR_CYC : HOLD_CYC;
    localparam int unsigned MAX_DLY = (PWRUP_CYC > CLEAR_T) ? PWRUP_CYC : CLEAR_T;

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] SETUP_L = CNT_W'(SETUP_CYC);
    localparam logic [CNT_W-1:0] PULSE_L = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_L  = CNT_W'(HOLD_CYC);
    localparam logic [CNT_W-1:0] EXEC_L  = CNT_W'(EXEC_T - 1);
    localparam logic [CNT_W-1:0] CLEAR_L = CNT_W'(CLEAR_T - 1);

    if (((64'(MAX_DLY) - 64'd1) >> CNT_W) != 64'd0) begin : g_cnt_w_chk
        $error("CNT_W too narrow for the longest delay");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rs_q, rs_d;
    logic [7:0]       db_q, db_d;
    logic             e_q, e_d;
    logic             clr_q, clr_d;
    logic             go, fin, go_rs;
    logic [7:0]       go_db;
    logic [CNT_W-1:0] post_m1, hold_len;

`ifdef LCD_INIT_EN
    localparam logic [CNT_W-1:0] PWRUP_L = CNT_W'(PWRUP_CYC - 1);

    logic       init_q, init_d;
    logic [2:0] idx_q, idx_d;

    function automatic logic [7:0] init_byte(input logic [2:0] i);
        case (i)
            3'd0, 3'd1, 3'd2, 3'd3: init_byte = 8'h38;
            3'd4:                   init_byte = 8'h0C;
            3'd5:                   init_byte = 8'h06;
            default:                init_byte = 8'h01;
        endcase
    endfunction
`endif

    // Post-fall delay minus the final cycle, which overlaps the next accept edge.
    assign post_m1  = clr_q ? CLEAR_L : EXEC_L;
    assign hold_len = (post_m1 <= HOLD_L) ? post_m1 : HOLD_L;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rs_d    = rs_q;
        db_d    = db_q;
        e_d     = e_q;
        clr_d   = clr_q;
        go      = 1'b0;
        fin     = 1'b0;
        go_rs   = wr.wr_rs;
        go_db   = wr.wr_data;
`ifdef LCD_INIT_EN
        init_d  = init_q;
        idx_d   = idx_q;
`endif
        unique case (state_q)
            S_IDLE: go = wr.wr_valid;
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_PULSE;
                    e_d     = 1'b1;
                    cnt_d   = PULSE_L;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            S_PULSE: begin
                if (cnt_q == '0) begin
                    e_d = 1'b0;
                    if (post_m1 == '0) begin
                        fin = 1'b1;
                    end else begin
                        state_d = S_HOLD;
                        cnt_d   = hold_len - ONE;
                    end
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    if (post_m1 <= HOLD_L) begin
                        fin = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = post_m1 - HOLD_L - ONE;
                    end
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) fin = 1'b1;
                else cnt_d = cnt_q - ONE;
            end
            S_PWRUP: begin
`ifdef LCD_INIT_EN
                if (cnt_q == PWRUP_L) begin
                    go    = 1'b1;
                    go_rs = 1'b0;
                    go_db = init_byte(3'd0);
                    idx_d = 3'd0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase

        if (fin) begin
            state_d = S_IDLE;
`ifdef LCD_INIT_EN
            if (init_q) begin
                if (idx_q == 3'd6) begin
                    init_d = 1'b0;
                end else begin
                    go    = 1'b1;
                    go_rs = 1'b0;
                    idx_d = idx_q + 3'd1;
                    go_db = init_byte(idx_q + 3'd1);
                end
            end
`endif
        end

        if (go) begin
            state_d = S_SETUP;
            cnt_d   = SETUP_L;
            rs_d    = go_rs;
            db_d    = go_db;
            clr_d   = ~go_rs & (go_db[7:2] == 6'd0) & (go_db[1:0] != 2'd0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
`ifdef LCD_INIT_EN
            state_q <= S_PWRUP;
            init_q  <= 1'b1;
            idx_q   <= 3'd0;
`else
            state_q <= S_IDLE;
`endif
            cnt_q   <= '0;
            rs_q    <= 1'b0;
            db_q    <= 8'h00;
            e_q     <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
`ifdef LCD_INIT_EN
            init_q  <= init_d;
            idx_q   <= idx_d;
`endif
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            db_q    <= db_d;
            e_q     <= e_d;
            clr_q   <= clr_d;
        end
    end

    assign wr.wr_ready = (state_q == S_IDLE);
    assign wr.busy     = (state_q != S_IDLE);
    assign lcd_rs      = rs_q;
    assign lcd_rw      = 1'b0;
    assign lcd_e       = e_q;
    assign lcd_db      = db_q;

endmodule

// File: tb/tb_lcd_hd44780_writer.sv
// Bench for lcd_hd44780_writer: timeline model of accepts plus directed vectors.
// Short sim timing: SETUP=2 PULSE=3 HOLD=2 EXEC=10 CLEAR=40 PWRUP=20.
module tb_lcd_hd44780_writer;

    localparam int S  = 2;
    localparam int P  = 3;
    localparam int H  = 2;
    localparam int EX = 10;
    localparam int CL = 40;
    localparam int PW = 20;
`ifdef LCD_INIT_EN
    localparam bit INIT = 1'b1;
`else
    localparam bit INIT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_db;

    lcd_hd44780_writer_if wif();

    lcd_hd44780_writer #(
        .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H),
        .EXEC_CYC(EX), .CLEAR_CYC(CL), .PWRUP_CYC(PW), .CNT_W(20)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr(wif),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_db(lcd_db)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    // Model: each launched byte occupies S+P+T cycles after its launch edge,
    // T = max(HOLD, EXEC or CLEAR); the next launch may happen one edge later.
    int         cyc = 0;
    int         acc = -100000;
    int         m_T = 1;
    int         pw  = 0;
    int         dacc = -1;
    bit         pw_on = 1'b0;
    logic       m_rs = 1'b0;
    logic [7:0] m_db = 8'h00;
    logic [7:0] init_q[$];

    function automatic int tot(input logic rs, input logic [7:0] d);
        int w;
        w = (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? CL : EX;
        return (w > H) ? w : H;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit         done, go;
        logic       lr;
        logic [7:0] ld;
        if (!rst_n) begin
            acc  = -100000;
            m_T  = 1;
            m_rs = 1'b0;
            m_db = 8'h00;
            pw   = 0;
            init_q.delete();
`ifdef LCD_INIT_EN
            pw_on  = 1'b1;
            init_q = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h0C, 8'h06, 8'h01};
`else
            pw_on = 1'b0;
`endif
        end else begin
            done = (cyc - acc) >= S + P + m_T;
            go = 1'b0;
            lr = 1'b0;
            ld = 8'h00;
            if (wif.wr_valid && wif.wr_ready) dacc = cyc + 1;
            if (pw_on) begin
                pw++;
                if (pw == PW) begin
                    pw_on = 1'b0;
                    go = 1'b1;
                    ld = init_q.pop_front();
                end
            end else if (done && init_q.size() > 0) begin
                go = 1'b1;
                ld = init_q.pop_front();
            end else if (done && wif.wr_valid) begin
                go = 1'b1;
                lr = wif.wr_rs;
                ld = wif.wr_data;
            end
            cyc++;
            if (go) begin
                acc  = cyc;
                m_rs = lr;
                m_db = ld;
                m_T  = tot(lr, ld);
            end
        end
    end

    int         rise_q[$];
    int         fall_q[$];
    logic [7:0] rdb_q[$];
    bit         e_prev = 1'b0;

    always @(negedge clk) begin
        bit ee, er;
        int d;
        d = cyc - acc;
        if (!rst_n) begin
            ee = 1'b0;
            er = !INIT;
        end else begin
            ee = (d >= S + 1) && (d <= S + P);
            er = !pw_on && (init_q.size() == 0) && (d >= S + P + m_T);
        end
        chk("lcd_e", lcd_e, ee);
        chk("lcd_rs", lcd_rs, m_rs);
        chk("lcd_db", lcd_db, m_db);
        chk("lcd_rw", lcd_rw, 0);
        chk("wr_ready", wif.wr_ready, er);
        chk("busy", wif.busy, !er);
        if (rst_n && lcd_e && !e_prev) begin
            rise_q.push_back(cyc);
            rdb_q.push_back(lcd_db);
        end
        if (rst_n && !lcd_e && e_prev) fall_q.push_back(cyc);
        e_prev = lcd_e;
    end

    task automatic clear_log();
        rise_q.delete();
        fall_q.delete();
        rdb_q.delete();
    endtask

    task automatic wait_ready(input int lim);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (wif.wr_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wait_ready_timeout", ok, 1);
    endtask

    // Returns accept cycle and the number of clocks until the next accept edge.
    task automatic send_measure(input logic rs, input logic [7:0] d,
                                output int a, output int lat);
        wait_ready(2000);
        clear_log();
        wif.wr_valid = 1'b1;
        wif.wr_rs    = rs;
        wif.wr_data  = d;
        @(posedge clk);
        #1 a = cyc;
        @(negedge clk);
        wif.wr_valid = 1'b0;
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            if (wif.wr_ready) begin
                lat = cyc - a + 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         a, lat, i;
        bit         found;
        logic [7:0] sb[3];
        sb = '{8'h48, 8'h49, 8'h21};
        wif.wr_valid = 1'b0;
        wif.wr_rs    = 1'b0;
        wif.wr_data  = 8'h00;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_db", lcd_db, 8'h00);
        chk("rst_e", lcd_e, 0);
        chk("rst_ready", wif.wr_ready, INIT ? 0 : 1);
        #1 rst_n = 1'b1;

`ifdef LCD_INIT_EN
        wait_ready(2000);
        chk("init_pulses", rise_q.size(), 7);
        if (rise_q.size() == 7) begin
            chk("init_b0", rdb_q[0], 8'h38);
            chk("init_b3", rdb_q[3], 8'h38);
            chk("init_b4", rdb_q[4], 8'h0C);
            chk("init_b5", rdb_q[5], 8'h06);
            chk("init_b6", rdb_q[6], 8'h01);
            chk("init_last_gap", cyc - fall_q[6] + 1, CL);
        end
`endif

        send_measure(1'b1, 8'h41, a, lat);
        chk("t1_ready_lat", lat, 16);
        chk("t1_pulses", rise_q.size(), 1);
        if (rise_q.size() == 1 && fall_q.size() == 1) begin
            chk("t1_e_delay", rise_q[0] - a, 3);
            chk("t1_e_width", fall_q[0] - rise_q[0], 3);
        end
        chk("t1_db_idle", lcd_db, 8'h41);
        chk("t1_rs_idle", lcd_rs, 1);

        send_measure(1'b0, 8'h01, a, lat);
        chk("t2_clear_lat", lat, 46);
        if (rise_q.size() == 1) chk("t2_e_delay", rise_q[0] - a, 3);
        send_measure(1'b0, 8'h80, a, lat);
        chk("t2_addr_lat", lat, 16);
        send_measure(1'b0, 8'h02, a, lat);
        chk("t2_home_lat", lat, 46);

        wait_ready(200);
        clear_log();
        i = 0;
        @(negedge clk);
        wif.wr_valid = 1'b1;
        wif.wr_rs    = 1'b1;
        wif.wr_data  = sb[0];
        for (int k = 0; k < 200 && i < 3; k++) begin
            @(posedge clk);
            #1;
            if (dacc == cyc) i++;
            @(negedge clk);
            if (i < 3) wif.wr_data = sb[i];
            else wif.wr_valid = 1'b0;
        end
        wif.wr_valid = 1'b0;
        chk("t3_accepts", i, 3);
        wait_ready(200);
        chk("t3_pulses", rise_q.size(), 3);
        if (rise_q.size() == 3) begin
            chk("t3_b0", rdb_q[0], 8'h48);
            chk("t3_b1", rdb_q[1], 8'h49);
            chk("t3_b2", rdb_q[2], 8'h21);
            chk("t3_gap01", rise_q[1] - rise_q[0], 16);
            chk("t3_gap12", rise_q[2] - rise_q[1], 16);
        end

        wait_ready(200);
        clear_log();
        wif.wr_valid = 1'b1;
        wif.wr_rs    = 1'b1;
        wif.wr_data  = 8'h55;
        @(negedge clk);
        wif.wr_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            wif.wr_valid = k[0];
            wif.wr_data  = 8'hAA;
        end
        wif.wr_valid = 1'b0;
        wait_ready(200);
        chk("t5_pulses", rise_q.size(), 1);
        chk("t5_db", lcd_db, 8'h55);

        wait_ready(200);
        wif.wr_valid = 1'b1;
        wif.wr_rs    = 1'b1;
        wif.wr_data  = 8'h5A;
        @(negedge clk);
        wif.wr_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (lcd_e) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("t4_e_seen", found, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_e_async", lcd_e, 0);
        chk("t4_db_async", lcd_db, 8'h00);
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t4_ready_after", wif.wr_ready, INIT ? 0 : 1);
        wait_ready(2000);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
